led_word_shifter: RTL

Downstream serializer for the LED string path. It accepts one 32-bit APA102-style word per start/busy handshake from the pattern generator and shifts it MSB-first onto the strip's SPI-like data/clock pair (`mosi`/`sck`). A word is a start frame, one tricolor LED, or an end frame, chosen by `type_input`.

---
 rtl/led_word_shifter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/led_word_shifter.sv
// APA102-style word serializer: shifts one 32-bit START/LED/END word MSB-first onto mosi/sck.
// Optional LEDSHIFT_CLAMP_EN limits each colour byte to MAX_COLOR_VALUE at accept.
module led_word_shifter #(
  parameter int unsigned CLK_DIV         = 2,
  parameter int unsigned BRIGHTNESS      = 31,
  parameter int unsigned MAX_COLOR_VALUE = 100
) (
  input  logic       ledshift_clk,
  input  logic       ledshift_reset,
  input  logic [7:0] blue_input,
  input  logic [7:0] green_input,
  input  logic [7:0] red_input,
  input  logic [1:0] type_input,
  input  logic       ledshift_start,
  output logic       ledshift_busy,
  output logic       mosi,
  output logic       sck
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0] BRIGHT   = 5'(BRIGHTNESS);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

`ifdef LEDSHIFT_CLAMP_EN
  localparam logic [7:0] MAX_COLOR = 8'(MAX_COLOR_VALUE);

  function automatic logic [7:0] color_limit(input logic [7:0] v);
    return (v > MAX_COLOR) ? MAX_COLOR : v;
  endfunction
`else
  function automatic logic [7:0] color_limit(input logic [7:0] v);
    return v;
  endfunction
`endif

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  div_q, div_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic [31:0] load_word;

  always_comb begin
    load_word = 32'h0000_0000;
    case (type_input)
      2'd1:    load_word = {3'b111, BRIGHT, color_limit(blue_input),
                            color_limit(green_input), color_limit(red_input)};
      2'd2:    load_word = 32'hFFFF_FFFF;
      default: load_word = 32'h0000_0000;
    endcase
  end

  // Next-state logic: divider paces each sck half-period; data only moves on the falling edge.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        sck_d = 1'b0;
        if (ledshift_start && (type_input != 2'd3)) begin
          shift_d   = load_word;
          mosi_d    = load_word[31];
          busy_d    = 1'b1;
          bit_cnt_d = 5'd31;
          div_d     = 8'd0;
          state_d   = LOW;
        end
      end
      LOW: begin
        if (div_q == DIV_LAST) begin
          div_d   = 8'd0;
          sck_d   = 1'b1;
          state_d = HIGH;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          sck_d = 1'b0;
          if (bit_cnt_q == 5'd0) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q - 5'd1;
            shift_d   = {shift_q[30:0], 1'b0};
            mosi_d    = shift_q[30];
            state_d   = LOW;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        sck_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ledshift_clk or negedge ledshift_reset) begin
    if (!ledshift_reset) begin
      state_q   <= IDLE;
      shift_q   <= 32'h0000_0000;
      bit_cnt_q <= 5'd31;
      div_q     <= 8'd0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
    end
  end

  assign ledshift_busy = busy_q;
  assign mosi          = mosi_q;
  assign sck           = sck_q;

endmodule
